// File: rtl/box_overlay.sv
// box_overlay: up to N_BOX framed boxes drawn over the pixel scan.
// Shadow config regs commit once per frame; optional bounce motion.
//
// Ports:
//   clk, reset      pixel clock, async active-low reset
//   Xpos, Ypos      current scan position from the timing generator
//   cfg_we/idx/addr/data  shadow register write port
//   frame_tick      one-cycle pulse on the commit cycle
//   red/green/blue  pixel colour, 2 cycles after Xpos/Ypos are sampled
module box_overlay #(
    parameter int          N_BOX  = 4,
    parameter int          X_W    = 11,
    parameter int          Y_W    = 10,
    parameter int          X_LIM  = 1055,
    parameter int          Y_LIM  = 524,
    parameter int          H_ACT  = 800,
    parameter int          V_ACT  = 480,
    parameter logic [23:0] BG_RGB = 24'h000000,
    localparam int         IW     = (N_BOX > 1) ? $clog2(N_BOX) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [X_W-1:0] Xpos,
    input  logic [Y_W-1:0] Ypos,
    input  logic           cfg_we,
    input  logic [IW-1:0]  cfg_idx,
    input  logic [2:0]     cfg_addr,
    input  logic [23:0]    cfg_data,
    output logic           frame_tick,
    output logic [7:0]     red,
    output logic [7:0]     green,
    output logic [7:0]     blue
);

    localparam int CW = ((X_W > Y_W) ? X_W : Y_W) + 2;

    localparam logic [CW-1:0]  HA = CW'(H_ACT);
    localparam logic [CW-1:0]  VA = CW'(V_ACT);
    localparam logic [X_W-1:0] XL = X_W'(X_LIM);
    localparam logic [Y_W-1:0] YL = Y_W'(Y_LIM);

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [Y_W-1:0] size;
        logic [7:0]     border;
        logic [23:0]    outer;
        logic [23:0]    inner;
        logic           en;
        logic           mv;
        logic [3:0]     dx;
        logic [3:0]     dy;
    } box_t;

    localparam box_t BOX_RST = '{
        x:      '0,
        y:      '0,
        size:   Y_W'(100),
        border: 8'd10,
        outer:  24'h0000FF,
        inner:  24'hDEDE00,
        en:     1'b0,
        mv:     1'b0,
        dx:     4'd0,
        dy:     4'd0
    };

    box_t shd_q [N_BOX];
    box_t shd_d [N_BOX];
    box_t act_q [N_BOX];
    box_t bnc   [N_BOX];

    logic             commit_q;
    logic [X_W-1:0]   px_q;
    logic [Y_W-1:0]   py_q;
    logic [N_BOX-1:0] ohit, ihit;
    logic [N_BOX-1:0] ohit_q, ihit_q;
    logic [23:0]      pix;
    logic [23:0]      rgb_q;

    // p + d with d a signed 4-bit step; a negative sum shows up as
    // the MSB set because CW leaves two bits of headroom over p.
    function automatic logic [CW-1:0] bpos(
        input logic [CW-1:0] p,
        input logic [CW-1:0] sz,
        input logic [3:0]    d,
        input logic [CW-1:0] lim
    );
        logic [CW-1:0] np;
        np = p + {{(CW-4){d[3]}}, d};
        if (sz > lim)
            bpos = '0;
        else if (np[CW-1])
            bpos = '0;
        else if (np + sz > lim)
            bpos = lim - sz;
        else
            bpos = np;
    endfunction

    function automatic logic [3:0] bdir(
        input logic [CW-1:0] p,
        input logic [CW-1:0] sz,
        input logic [3:0]    d,
        input logic [CW-1:0] lim
    );
        logic [CW-1:0] np;
        np = p + {{(CW-4){d[3]}}, d};
        if (sz > lim)
            bdir = d;
        else if (np[CW-1] || (np + sz > lim))
            bdir = ~d + 4'd1;
        else
            bdir = d;
    endfunction

    // Values loaded into active (and written back to shadow) at commit.
    always_comb begin
        for (int i = 0; i < N_BOX; i++) begin
            bnc[i] = shd_q[i];
            if (shd_q[i].mv) begin
                bnc[i].x  = X_W'(bpos(CW'(shd_q[i].x),
                    CW'(shd_q[i].size), shd_q[i].dx, HA));
                bnc[i].dx = bdir(CW'(shd_q[i].x),
                    CW'(shd_q[i].size), shd_q[i].dx, HA);
                bnc[i].y  = Y_W'(bpos(CW'(shd_q[i].y),
                    CW'(shd_q[i].size), shd_q[i].dy, VA));
                bnc[i].dy = bdir(CW'(shd_q[i].y),
                    CW'(shd_q[i].size), shd_q[i].dy, VA);
            end
        end
    end

    // A cfg write lands after the bounce update so it wins in shadow.
    always_comb begin
        for (int i = 0; i < N_BOX; i++) begin
            shd_d[i] = commit_q ? bnc[i] : shd_q[i];
            if (cfg_we && (cfg_idx == IW'(i))) begin
                case (cfg_addr)
                    3'd0: shd_d[i].x      = cfg_data[X_W-1:0];
                    3'd1: shd_d[i].y      = cfg_data[Y_W-1:0];
                    3'd2: shd_d[i].size   = cfg_data[Y_W-1:0];
                    3'd3: shd_d[i].border = cfg_data[7:0];
                    3'd4: shd_d[i].outer  = cfg_data;
                    3'd5: shd_d[i].inner  = cfg_data;
                    3'd6: begin
                        shd_d[i].en = cfg_data[0];
                        shd_d[i].mv = cfg_data[1];
                        shd_d[i].dx = cfg_data[7:4];
                        shd_d[i].dy = cfg_data[11:8];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Hit test on the registered scan position, no wrap-around.
    always_comb begin
        logic [CW-1:0] xs, xe, ys, ye, bw, px, py;
        logic          solid;
        ohit  = '0;
        ihit  = '0;
        xs    = '0;
        xe    = '0;
        ys    = '0;
        ye    = '0;
        bw    = '0;
        solid = 1'b0;
        px    = CW'(px_q);
        py    = CW'(py_q);
        for (int i = 0; i < N_BOX; i++) begin
            xs    = CW'(act_q[i].x);
            ys    = CW'(act_q[i].y);
            xe    = xs + CW'(act_q[i].size);
            ye    = ys + CW'(act_q[i].size);
            bw    = CW'(act_q[i].border);
            solid = (bw + bw) >= CW'(act_q[i].size);
            ohit[i] = act_q[i].en && (act_q[i].size != '0)
                && (px >= xs) && (px < xe)
                && (py >= ys) && (py < ye);
            ihit[i] = ohit[i] && !solid
                && (px >= xs + bw) && (px < xe - bw)
                && (py >= ys + bw) && (py < ye - bw);
        end
    end

    // Lowest index wins: scan downwards so it is assigned last.
    always_comb begin
        pix = BG_RGB;
        for (int i = N_BOX - 1; i >= 0; i--) begin
            if (ohit_q[i])
                pix = ihit_q[i] ? act_q[i].inner : act_q[i].outer;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_BOX; i++) begin
                shd_q[i] <= BOX_RST;
                act_q[i] <= BOX_RST;
            end
            commit_q   <= 1'b0;
            frame_tick <= 1'b0;
            px_q       <= '0;
            py_q       <= '0;
            ohit_q     <= '0;
            ihit_q     <= '0;
            rgb_q      <= '0;
        end else begin
            for (int i = 0; i < N_BOX; i++) begin
                shd_q[i] <= shd_d[i];
                if (commit_q)
                    act_q[i] <= bnc[i];
            end
            commit_q   <= (Xpos == XL) && (Ypos == YL);
            frame_tick <= commit_q;
            px_q       <= Xpos;
            py_q       <= Ypos;
            ohit_q     <= ohit;
            ihit_q     <= ihit;
            rgb_q      <= pix;
        end
    end

    assign red   = rgb_q[23:16];
    assign green = rgb_q[15:8];
    assign blue  = rgb_q[7:0];

endmodule
